// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store opcode numbers, LSU state encoding,
// access widths and small opcode-decoding helpers.
package cpu_pkg;

  localparam logic [31:0] OP_LB  = 32'd27;
  localparam logic [31:0] OP_LH  = 32'd28;
  localparam logic [31:0] OP_LW  = 32'd29;
  localparam logic [31:0] OP_LBU = 32'd30;
  localparam logic [31:0] OP_LHU = 32'd31;
  localparam logic [31:0] OP_SB  = 32'd32;
  localparam logic [31:0] OP_SH  = 32'd33;
  localparam logic [31:0] OP_SW  = 32'd34;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } access_width_t;

  function automatic logic op_is_lsu(input logic [31:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_load(input logic [31:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic op_is_signed(input logic [31:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic access_width_t op_width(input logic [31:0] op);
    access_width_t w;
    case (op)
      OP_LB, OP_LBU, OP_SB: w = ACC_BYTE;
      OP_LH, OP_LHU, OP_SH: w = ACC_HALF;
      default:              w = ACC_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables and replicated write data for stores,
// read-data shift and sign/zero extension for loads. Purely combinational.
module lsu_align
  import cpu_pkg::*;
(
  input  access_width_t i_width,
  input  logic          i_signed,
  input  logic [1:0]    i_ea_lo,
  input  logic [31:0]   i_sdata,
  input  logic [31:0]   i_rdata,
  output logic [3:0]    o_be,
  output logic [31:0]   o_wdata,
  output logic [31:0]   o_ldata
);

  logic [31:0] w_shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_be      = 4'b0000;
    o_wdata   = 32'h0;
    o_ldata   = 32'h0;
    w_shifted = 32'h0;
    case (i_width)
      ACC_BYTE: begin
        o_be      = 4'b0001 << i_ea_lo;
        o_wdata   = {4{i_sdata[7:0]}};
        w_shifted = i_rdata >> {i_ea_lo, 3'b000};
        o_ldata   = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      ACC_HALF: begin
        // Half-word lane follows EA[1] only; EA[0] never moves the lane.
        o_be      = 4'b0011 << {i_ea_lo[1], 1'b0};
        o_wdata   = {2{i_sdata[15:0]}};
        w_shifted = i_rdata >> {i_ea_lo[1], 4'b0000};
        o_ldata   = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_sdata;
        o_ldata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one handshaked data-bus access per load/store opcode with
// bus timeout. Optional misaligned-access trap under LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_IR,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  output logic [31:0] o_loaddata,
  output logic        o_load_regfile,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_bus_err,
  output logic        o_misaligned
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t    r_state;
  access_width_t r_width;
  logic          r_load;
  logic          r_signed;
  logic [31:0]   r_ea;
  logic [31:0]   r_b;
  logic [CNT_W-1:0] r_cnt;
  logic          r_rd;
  logic          r_wr;
  logic [31:0]   r_loaddata;
  logic          r_done;
  logic          r_load_regfile;
  logic          r_bus_err;
  logic          r_misaligned;

  logic          w_valid;
  logic          w_is_load;
  access_width_t w_width;
  logic [31:0]   w_imm;
  logic [31:0]   w_ea;
  logic          w_misaligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ldata;
  logic          w_unused;

  assign w_valid   = op_is_lsu(i_instruction);
  assign w_is_load = op_is_load(i_instruction);
  assign w_width   = op_width(i_instruction);
  assign w_imm     = w_is_load ? {{20{i_IR[31]}}, i_IR[31:20]}
                               : {{20{i_IR[31]}}, i_IR[31:25], i_IR[11:7]};
  assign w_ea      = i_A + w_imm;
  assign w_unused  = &{1'b0, i_IR[19:12], i_IR[6:0]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = ((w_width == ACC_HALF) && w_ea[0]) ||
                        ((w_width == ACC_WORD) && (w_ea[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  lsu_align u_align (
    .i_width  (r_width),
    .i_signed (r_signed),
    .i_ea_lo  (r_ea[1:0]),
    .i_sdata  (r_b),
    .i_rdata  (i_bus_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_ldata  (w_ldata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= LSU_IDLE;
      r_width        <= ACC_BYTE;
      r_load         <= 1'b0;
      r_signed       <= 1'b0;
      r_ea           <= 32'h0;
      r_b            <= 32'h0;
      r_cnt          <= '0;
      r_rd           <= 1'b0;
      r_wr           <= 1'b0;
      r_loaddata     <= 32'h0;
      r_done         <= 1'b0;
      r_load_regfile <= 1'b0;
      r_bus_err      <= 1'b0;
      r_misaligned   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; these defaults make the status outputs single-cycle pulses.
      r_done         <= 1'b0;
      r_load_regfile <= 1'b0;
      r_bus_err      <= 1'b0;
      r_misaligned   <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (i_start && w_valid) begin
            r_width  <= w_width;
            r_load   <= w_is_load;
            r_signed <= op_is_signed(i_instruction);
            r_ea     <= w_ea;
            r_b      <= i_B;
            r_cnt    <= '0;
            if (w_misaligned) begin
              r_state      <= LSU_DONE;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
            end else begin
              r_state <= LSU_ACCESS;
              r_rd    <= w_is_load;
              r_wr    <= ~w_is_load;
            end
          end
        end
        LSU_ACCESS: begin
          if (i_bus_ack) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= LSU_DONE;
            r_done  <= 1'b1;
            if (r_load) begin
              r_loaddata     <= w_ldata;
              r_load_regfile <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_state   <= LSU_DONE;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LSU_DONE: r_state <= LSU_IDLE;
        default:  r_state <= LSU_IDLE;
      endcase
    end
  end

  // Lane enables are only meaningful while a strobe is up.
  assign o_bus_be       = (r_rd | r_wr) ? w_be : 4'b0000;
  assign o_bus_addr     = {r_ea[31:2], 2'b00};
  assign o_bus_wdata    = w_wdata;
  assign o_bus_rd       = r_rd;
  assign o_bus_wr       = r_wr;
  assign o_loaddata     = r_loaddata;
  assign o_load_regfile = r_load_regfile;
  assign o_done         = r_done;
  assign o_busy         = (r_state != LSU_IDLE);
  assign o_bus_err      = r_bus_err;
  assign o_misaligned   = r_misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// loads/stores against a behavioural model of the bus transaction.
module tb_load_store_unit;
  import cpu_pkg::*;

  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_instruction = 32'h0;
  logic [31:0] i_IR = 32'h0;
  logic [31:0] i_A = 32'h0;
  logic [31:0] i_B = 32'h0;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        o_bus_rd;
  logic        o_bus_wr;
  logic [31:0] i_bus_rdata = 32'h0;
  logic        i_bus_ack = 1'b0;
  logic [31:0] o_loaddata;
  logic        o_load_regfile;
  logic        o_done;
  logic        o_busy;
  logic        o_bus_err;
  logic        o_misaligned;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_ld = 32'h0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_instruction  (i_instruction),
    .i_IR           (i_IR),
    .i_A            (i_A),
    .i_B            (i_B),
    .o_bus_addr     (o_bus_addr),
    .o_bus_wdata    (o_bus_wdata),
    .o_bus_be       (o_bus_be),
    .o_bus_rd       (o_bus_rd),
    .o_bus_wr       (o_bus_wr),
    .i_bus_rdata    (i_bus_rdata),
    .i_bus_ack      (i_bus_ack),
    .o_loaddata     (o_loaddata),
    .o_load_regfile (o_load_regfile),
    .o_done         (o_done),
    .o_busy         (o_busy),
    .o_bus_err      (o_bus_err),
    .o_misaligned   (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ir_ld(input logic [11:0] imm);
    return {imm, 5'd1, 3'b010, 5'd2, 7'h03};
  endfunction

  function automatic logic [31:0] ir_st(input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], 7'h23};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_rd"}, o_bus_rd, 0);
    check({tag, "_wr"}, o_bus_wr, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_ldrf"}, o_load_regfile, 0);
  endtask

  // One full transaction. ack_dly = index of the strobe cycle carrying ack, <0 = never.
  task automatic run_op(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ir, input int ack_dly, input logic [31:0] rdata,
                        input bit noisy);
    bit          is_load, sgn, trap, err;
    int          wid, lane;
    logic [31:0] imm, ea, exp_be, exp_wd, mask, val;
    is_load = (op <= OP_LHU);
    sgn     = (op == OP_LB) || (op == OP_LH);
    wid     = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
              (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
    imm     = is_load ? {{20{ir[31]}}, ir[31:20]} : {{20{ir[31]}}, ir[31:25], ir[11:7]};
    ea      = a + imm;
    trap    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap    = (ea % wid) != 0;
`endif
    lane    = (wid == 4) ? 0 : (wid == 2) ? (ea[1] ? 2 : 0) : int'(ea[1:0]);
    exp_be  = ((32'd1 << wid) - 1) << lane;
    exp_wd  = (wid == 1) ? {4{b[7:0]}} : (wid == 2) ? {2{b[15:0]}} : b;
    if (wid == 4) val = rdata;
    else begin
      mask = (32'd1 << (8 * wid)) - 1;
      val  = (rdata >> (8 * lane)) & mask;
      if (sgn && val[8 * wid - 1]) val = val | ~mask;
    end
    err = !trap && (ack_dly < 0 || ack_dly >= TO);

    @(negedge i_clk);
    i_instruction = op; i_A = a; i_B = b; i_IR = ir; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    if (trap) begin
      check("trap_done", o_done, 1);
      check("trap_mis", o_misaligned, 1);
      check("trap_rd", o_bus_rd, 0);
      check("trap_wr", o_bus_wr, 0);
      check("trap_ldrf", o_load_regfile, 0);
      check("trap_ld", o_loaddata, exp_ld);
    end else begin
      for (int i = 0; i < TO; i++) begin
        check("acc_rd", o_bus_rd, is_load);
        check("acc_wr", o_bus_wr, !is_load);
        check("acc_addr", o_bus_addr, ea & 32'hFFFF_FFFC);
        check("acc_be", o_bus_be, exp_be);
        if (!is_load) check("acc_wdata", o_bus_wdata, exp_wd);
        check("acc_done", o_done, 0);
        if (i == ack_dly) begin
          i_bus_ack = 1'b1; i_bus_rdata = rdata;
        end else i_bus_rdata = $urandom;
        if (noisy) begin
          i_start = (i % 2 == 0);
          i_instruction = 32'd27 + $urandom_range(0, 7);
          i_A = $urandom;
        end
        @(negedge i_clk);
        i_bus_ack = 1'b0; i_start = 1'b0;
        if (i == ack_dly) break;
      end
      if (!err && is_load) exp_ld = val;
      check("dn_done", o_done, 1);
      check("dn_ldrf", o_load_regfile, is_load && !err);
      check("dn_err", o_bus_err, err);
      check("dn_rd", o_bus_rd, 0);
      check("dn_wr", o_bus_wr, 0);
      check("dn_mis", o_misaligned, 0);
      check("dn_ld", o_loaddata, exp_ld);
    end
    check("dn_busy", o_busy, 1);
    if (noisy) begin
      i_start = 1'b1; i_instruction = OP_LW;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    check_idle("post");
    check("post_ld", o_loaddata, exp_ld);
  endtask

  initial begin
    // Reset state
    @(negedge i_clk);
    check_idle("rst");
    check("rst_addr", o_bus_addr, 0);
    check("rst_be", o_bus_be, 0);
    check("rst_wdata", o_bus_wdata, 0);
    check("rst_ld", o_loaddata, 0);
    check("rst_err", o_bus_err, 0);
    check("rst_mis", o_misaligned, 0);
    i_rst = 1'b0;

    // Directed cases
    run_op(OP_LW,  32'h1000, 32'h0, ir_ld(12'd4), 1, 32'hDEAD_BEEF, 0);
    run_op(OP_LB,  32'h2000, 32'h0, ir_ld(12'd3), 0, 32'h80FF_FFFF, 0);
    run_op(OP_LBU, 32'h2000, 32'h0, ir_ld(12'd3), 2, 32'h80FF_FFFF, 0);
    run_op(OP_SH,  32'h3000, 32'h1234_ABCD, ir_st(12'd2), 3, 32'h0, 0);
    run_op(OP_LW,  32'h4000, 32'h0, ir_ld(12'd0), -1, 32'h0, 1);
    run_op(OP_SW,  32'h4000, 32'h5555_AAAA, ir_st(12'd8), -1, 32'h0, 1);
    run_op(OP_LW,  32'h1001, 32'h0, ir_ld(12'd0), 1, 32'h0BAD_F00D, 0);
    run_op(OP_LH,  32'h0010, 32'h0, ir_ld(12'hFFE), 0, 32'h8001_7FFF, 0);
    run_op(OP_LHU, 32'hFFFF_FFFE, 32'h0, ir_ld(12'd4), 7, 32'h8001_7FFF, 0);
    run_op(OP_SB,  32'h0000_0005, 32'hCAFE_BA5E, ir_st(12'hFFF), 0, 32'h0, 0);

    // Non-load/store opcodes are ignored
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_instruction = (k == 0) ? 32'd0 : (k == 1) ? 32'd26 : 32'd35;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check_idle("badop");
    end

    // Ack outside an access is ignored
    @(negedge i_clk);
    i_bus_ack = 1'b1; i_bus_rdata = 32'h1234_5678;
    @(negedge i_clk);
    i_bus_ack = 1'b0;
    check_idle("stray_ack");
    check("stray_ack_ld", o_loaddata, exp_ld);

    // Reset in the middle of an access
    @(negedge i_clk);
    i_instruction = OP_LW; i_A = 32'h5000; i_IR = ir_ld(12'd0); i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("mid_rd_up", o_bus_rd, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("mid_rst_rd", o_bus_rd, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    exp_ld = 32'h0;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_bus_ack = 1'b1; i_bus_rdata = 32'hFEED_FACE;
    @(negedge i_clk);
    i_bus_ack = 1'b0;
    check_idle("mid_after");
    check("mid_after_ld", o_loaddata, exp_ld);
    run_op(OP_LW, 32'h5000, 32'h0, ir_ld(12'd0), 1, 32'h0102_0304, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] op;
      int          dly;
      op  = 32'd27 + $urandom_range(0, 7);
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      run_op(op, $urandom, $urandom, $urandom, dly, $urandom, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
